dpram_fifo_ctrl: RTL and testbench

- Upstream controller for the 64x8 dual-port RAM. Turns the RAM into a synchronous FIFO with valid/ready handshakes.
- Port 1 of the RAM is driven write-only from the producer side. Port 2 is driven read-only to the consumer side.
- Owns write/read pointers, occupancy and the 1-cycle RAM read latency. A 2-entry output skid buffer sustains one pop per cycle.

---
 rtl/dpram_fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// Synchronous FIFO controller around a 64x8 dual-port RAM: port 1 writes, port 2 reads,
// 2-entry skid buffer hides the registered read latency. Optional flags: DPRAM_FIFO_ERR_EN.
module dpram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] ram_data1,
  output logic [ADDR_W-1:0] ram_adr1,
  output logic              ram_we1,
  output logic [ADDR_W-1:0] ram_adr2,
  output logic              ram_we2,
`ifdef DPRAM_FIFO_ERR_EN
  output logic              err_ovf,
  output logic              err_udf,
`endif
  input  logic [DATA_W-1:0] ram_q2
);

  localparam int unsigned CntW = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   mem_cnt_q, mem_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        skid_cnt_q, skid_cnt_d;
  logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
  logic              push, pop, issue;
  logic [2:0]        skid_load;

  assign wr_ready  = (mem_cnt_q < CntW'(DEPTH));
  assign rd_valid  = (skid_cnt_q != 2'd0);
  assign rd_data   = head_q;
  assign push      = wr_valid & wr_ready;
  assign pop       = rd_valid & rd_ready;

  // Occupancy of the skid buffer once everything already committed has landed.
  assign skid_load = {1'b0, skid_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign issue     = (mem_cnt_q != '0) && (skid_load < 3'd2);

  assign ram_we1   = push;
  assign ram_adr1  = wr_ptr_q;
  assign ram_data1 = wr_data;
  assign ram_adr2  = rd_ptr_q;
  assign ram_we2   = 1'b0;

  always_comb begin
    wr_ptr_d  = push  ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d  = issue ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    mem_cnt_d = mem_cnt_q + CntW'(push) - CntW'(issue);
    rd_pend_d = issue;
  end

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    skid_cnt_d = skid_cnt_q;
    case ({rd_pend_q, pop})
      2'b01: begin
        head_d     = tail_q;
        skid_cnt_d = skid_cnt_q - 2'd1;
      end
      2'b10: begin
        if (skid_cnt_q == 2'd0) head_d = ram_q2;
        else                    tail_d = ram_q2;
        skid_cnt_d = skid_cnt_q + 2'd1;
      end
      2'b11: begin
        if (skid_cnt_q == 2'd1) begin
          head_d = ram_q2;
        end else begin
          head_d = tail_q;
          tail_d = ram_q2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      rd_pend_q  <= rd_pend_d;
      skid_cnt_q <= skid_cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

`ifdef DPRAM_FIFO_ERR_EN
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (wr_valid & ~wr_ready);
    err_udf_d = err_udf_q | (rd_ready & ~rd_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  // Overflow and underflow attempts are dropped without any record.
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural 64x8 registered-read RAM.
module tb_dpram_fifo_ctrl;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DATA_W-1:0] wr_data, rd_data, ram_data1, ram_q2;
  logic [ADDR_W-1:0] ram_adr1, ram_adr2;
  logic              ram_we1, ram_we2;
`ifdef DPRAM_FIFO_ERR_EN
  logic              err_ovf, err_udf;
`endif

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .ram_data1 (ram_data1),
    .ram_adr1  (ram_adr1),
    .ram_we1   (ram_we1),
    .ram_adr2  (ram_adr2),
    .ram_we2   (ram_we2),
`ifdef DPRAM_FIFO_ERR_EN
    .err_ovf   (err_ovf),
    .err_udf   (err_udf),
`endif
    .ram_q2    (ram_q2)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    ram_q2 <= ram[ram_adr2];
    if (ram_we1) ram[ram_adr1] <= ram_data1;
  end

  int                n_tests = 0;
  int                n_fail  = 0;
  logic [DATA_W-1:0] sb [$];
  logic [ADDR_W-1:0] exp_wr_ptr = '0;
  logic [ADDR_W-1:0] prev_adr2  = '0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  int                wraps1 = 0;
  int                wraps2 = 0;
  int                pops   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One clock: check and score the cycle about to be committed, then advance past the edge.
  task automatic tick();
    logic [DATA_W-1:0] e;
    #1;
    if (!rst) begin
      check_eq("ram_we1", 32'(ram_we1), 32'(wr_valid && wr_ready));
      check_eq("ram_we2", 32'(ram_we2), 32'd0);
      if (prev_stall) begin
        check_eq("stall_valid", 32'(rd_valid), 32'd1);
        check_eq("stall_data", 32'(rd_data), 32'(prev_data));
      end
      if (wr_valid && wr_ready) begin
        check_eq("ram_adr1", 32'(ram_adr1), 32'(exp_wr_ptr));
        check_eq("ram_data1", 32'(ram_data1), 32'(wr_data));
        sb.push_back(wr_data);
        if (ram_adr1 == 6'd63) wraps1++;
        exp_wr_ptr = exp_wr_ptr + 6'd1;
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) begin
          check_eq("pop_with_empty_sb", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          check_eq("rd_data", 32'(rd_data), 32'(e));
          pops++;
        end
      end
      if (ram_adr2 == 6'd0 && prev_adr2 == 6'd63) wraps2++;
      prev_adr2  = ram_adr2;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    sb.delete();
    exp_wr_ptr = '0;
    prev_adr2  = '0;
  endtask

  task automatic drain(input int max_cycles);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0 && !rd_valid) break;
      tick();
    end
    check_eq("drain_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("drain_rd_valid", 32'(rd_valid), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  initial begin
    int acc;
    int d;
    int gaps;
    int pops0;
    logic seen;
    logic accepted;
    logic pat [6];

    rst = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(2);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_data", 32'(rd_data), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_ram_adr2", 32'(ram_adr2), 32'd0);

    // Single word latency: push edge, issue edge, capture edge.
    wr_valid = 1'b1; wr_data = 8'hA5;
    #1;
    check_eq("single_we1", 32'(ram_we1), 32'd1);
    check_eq("single_adr1", 32'(ram_adr1), 32'd0);
    tick();
    wr_valid = 1'b0;
    check_eq("single_adr2", 32'(ram_adr2), 32'd0);
    check_eq("single_valid_c1", 32'(rd_valid), 32'd0);
    tick();
    check_eq("single_valid_c2", 32'(rd_valid), 32'd0);
    tick();
    check_eq("single_valid_c3", 32'(rd_valid), 32'd1);
    check_eq("single_data", 32'(rd_data), 32'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("single_after_pop", 32'(rd_valid), 32'd0);

    // Fill to full with the consumer stalled.
    acc = 0;
    for (int i = 0; i < 70; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(acc);
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    check_eq("fill_accepted", 32'(acc), 32'd66);
    check_eq("fill_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("fill_sb_size", 32'(sb.size()), 32'd66);
    pops0 = pops;
    drain(100);
    check_eq("fill_pops", 32'(pops - pops0), 32'd66);

    // Streaming with wrap.
    wraps1 = 0; wraps2 = 0; d = 0; gaps = 0; seen = 1'b0;
    pops0 = pops;
    rd_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && d < 200; cyc++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(d);
      accepted = wr_ready;
      if (seen && !rd_valid) gaps++;
      if (rd_valid) seen = 1'b1;
      tick();
      if (accepted) d++;
    end
    check_eq("stream_pushed", 32'(d), 32'd200);
    check_eq("stream_gaps", 32'(gaps), 32'd0);
    drain(20);
    check_eq("stream_pops", 32'(pops - pops0), 32'd200);
    check_eq("stream_wrap1", 32'(wraps1 >= 3), 32'd1);
    check_eq("stream_wrap2", 32'(wraps2 >= 3), 32'd1);

    // Back-pressure stability.
    pops0 = pops;
    rd_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      rd_ready = pat[i];
      tick();
    end
    rd_ready = 1'b0;
    check_eq("bp_pops", 32'(pops - pops0), 32'd3);
    check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);
    check_eq("bp_rd_valid", 32'(rd_valid), 32'd0);

    // Reset with words in flight and a RAM read pending.
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(8'h80 + i);
      tick();
    end
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    tick();
    do_reset(1);
    check_eq("mrst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("mrst_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    check_eq("mrst_rd_valid2", 32'(rd_valid), 32'd0);
    pops0 = pops;
    wr_valid = 1'b1; wr_data = 8'h3C;
    tick();
    drain(10);
    check_eq("mrst_pops", 32'(pops - pops0), 32'd1);

`ifdef DPRAM_FIFO_ERR_EN
    do_reset(1);
    check_eq("err_ovf_rst", 32'(err_ovf), 32'd0);
    check_eq("err_udf_rst", 32'(err_udf), 32'd0);
    rd_ready = 1'b0;
    for (int i = 0; i < 66; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    check_eq("err_full", 32'(wr_ready), 32'd0);
    check_eq("err_ovf_pre", 32'(err_ovf), 32'd0);
    tick();
    wr_valid = 1'b0;
    check_eq("err_ovf_set", 32'(err_ovf), 32'd1);
    tick();
    tick();
    check_eq("err_ovf_sticky", 32'(err_ovf), 32'd1);
    check_eq("err_udf_quiet", 32'(err_udf), 32'd0);
    do_reset(1);
    check_eq("err_ovf_clr", 32'(err_ovf), 32'd0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check_eq("err_udf_set", 32'(err_udf), 32'd1);
    tick();
    check_eq("err_udf_sticky", 32'(err_udf), 32'd1);
    do_reset(1);
    check_eq("err_ovf_clr2", 32'(err_ovf), 32'd0);
    check_eq("err_udf_clr", 32'(err_udf), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
